// File: rtl/sram_bus_ctrl.sv
// Bridges the core's valid/ready memory bus onto a single-port synchronous SRAM
// macro, with an optional zero-fill sweep of the whole array after reset.
module sram_bus_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   input  logic [3:0]            mem_wstrb_i,
   output logic [31:0]           mem_rdata_o,
   output logic                  init_done_o,
   output logic                  sram_cs_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [31:0]           sram_data_o,
   output logic [3:0]            sram_mask_o,
   output logic                  sram_wren_o,
   input  logic [31:0]           sram_data_i
);

   typedef enum logic [1:0] {INIT, IDLE, WR_ACK, RD_ACK} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;

   // Byte-offset bits and bits above the array depth alias onto the same word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr_i[1:0], mem_addr_i[31:ADDR_WIDTH+2]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if (INIT_EN) begin
            state <= INIT;
         end else begin
            state <= IDLE;
         end
         init_cnt <= '0;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + ADDR_WIDTH'(1);
               if (init_cnt == LAST_ADDR) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (mem_valid_i) begin
                  if (mem_wstrb_i != 4'd0) begin
                     state <= WR_ACK;
                  end else begin
                     state <= RD_ACK;
                  end
               end
            end
            WR_ACK:  state <= IDLE;
            RD_ACK:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The SRAM is driven in the same cycle a request is accepted; gating with
   // reset lets an in-flight access be abandoned without waiting for a clock.
   always_comb begin
      sram_cs_o   = 1'b0;
      sram_addr_o = '0;
      sram_data_o = 32'd0;
      sram_mask_o = 4'd0;
      sram_wren_o = 1'b0;
      mem_rdata_o = 32'd0;
      if (!rst_i) begin
         case (state)
            INIT: begin
               sram_cs_o   = 1'b1;
               sram_wren_o = 1'b1;
               sram_mask_o = 4'hF;
               sram_addr_o = init_cnt;
            end
            IDLE: begin
               if (mem_valid_i) begin
                  sram_cs_o   = 1'b1;
                  sram_addr_o = mem_addr_i[ADDR_WIDTH+1:2];
                  if (mem_wstrb_i != 4'd0) begin
                     sram_wren_o = 1'b1;
                     sram_mask_o = mem_wstrb_i;
                     sram_data_o = mem_wdata_i;
                  end
               end
            end
            RD_ACK:  mem_rdata_o = sram_data_i;
            default: ;
         endcase
      end
   end

   assign mem_ready_o = !rst_i && ((state == WR_ACK) || (state == RD_ACK));
   assign init_done_o = !rst_i && (state != INIT);

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: one instance with the init sweep, one without,
// both at ADDR_WIDTH=4 so the full sweep is short enough to watch cycle by cycle.
module tb_sram_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memValid;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memWstrb;

   logic        memReady, initDone, sramCs, sramWren;
   logic [31:0] memRdata, sramData;
   logic [3:0]  sramAddr, sramMask;
   logic [31:0] sramQ;

   logic        memReadyB, initDoneB, sramCsB, sramWrenB;
   logic [31:0] memRdataB, sramDataB;
   logic [3:0]  sramAddrB, sramMaskB;
   logic [31:0] sramQB;

   logic [31:0] sramArray [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign sramQB = 32'd0;

   sram_bus_ctrl #(.ADDR_WIDTH(4), .INIT_EN(1'b1)) u0 (
      .clk_i(clk), .rst_i(rst),
      .mem_valid_i(memValid), .mem_ready_o(memReady),
      .mem_addr_i(memAddr), .mem_wdata_i(memWdata), .mem_wstrb_i(memWstrb),
      .mem_rdata_o(memRdata), .init_done_o(initDone),
      .sram_cs_o(sramCs), .sram_addr_o(sramAddr), .sram_data_o(sramData),
      .sram_mask_o(sramMask), .sram_wren_o(sramWren), .sram_data_i(sramQ)
   );

   sram_bus_ctrl #(.ADDR_WIDTH(4), .INIT_EN(1'b0)) u1 (
      .clk_i(clk), .rst_i(rst),
      .mem_valid_i(memValid), .mem_ready_o(memReadyB),
      .mem_addr_i(memAddr), .mem_wdata_i(memWdata), .mem_wstrb_i(memWstrb),
      .mem_rdata_o(memRdataB), .init_done_o(initDoneB),
      .sram_cs_o(sramCsB), .sram_addr_o(sramAddrB), .sram_data_o(sramDataB),
      .sram_mask_o(sramMaskB), .sram_wren_o(sramWrenB), .sram_data_i(sramQB)
   );

   // Behavioural SRAM macro: masked byte writes, one-cycle registered read.
   initial begin
      for (int i = 0; i < 16; i++) sramArray[i] = 32'hA5A5_A5A5;
   end

   always @(posedge clk) begin
      if (sramCs) begin
         if (sramWren) begin
            for (int b = 0; b < 4; b++) begin
               if (sramMask[b]) sramArray[sramAddr][8*b +: 8] <= sramData[8*b +: 8];
            end
         end else begin
            sramQ <= sramArray[sramAddr];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      memValid = valid;
      memAddr  = addr;
      memWdata = wdata;
      memWstrb = wstrb;
   endtask

   // Starts in IDLE, issues one access, checks the ACK cycle and the ready drop.
   // Valid stays high on return so consecutive calls model a continuous request.
   task automatic doAccess(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] expRdata);
      logic [31:0] a;
      logic        isWrite;
      a = addr;
      isWrite = (wstrb != 4'd0);
      applyStimulus(1'b1, addr, wdata, wstrb);
      #1;
      checkOutput("issue_cs",    32'(sramCs),   32'd1);
      checkOutput("issue_wren",  32'(sramWren), 32'(isWrite));
      checkOutput("issue_addr",  32'(sramAddr), {28'd0, a[5:2]});
      checkOutput("issue_mask",  32'(sramMask), 32'(wstrb));
      checkOutput("issue_data",  sramData,      isWrite ? wdata : 32'd0);
      checkOutput("issue_ready", 32'(memReady), 32'd0);
      @(negedge clk);
      checkOutput("ack_ready", 32'(memReady), 32'd1);
      checkOutput("ack_cs",    32'(sramCs),   32'd0);
      checkOutput("ack_rdata", memRdata,      expRdata);
      @(negedge clk);
      checkOutput("ready_pulse_end", 32'(memReady), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_ready",     32'(memReady),  32'd0);
      checkOutput("rst_rdata",     memRdata,       32'd0);
      checkOutput("rst_init_done", 32'(initDone),  32'd0);
      checkOutput("rst_cs",        32'(sramCs),    32'd0);
      checkOutput("rst_wren",      32'(sramWren),  32'd0);
      checkOutput("rst_mask",      32'(sramMask),  32'd0);
      checkOutput("rst_b_done",    32'(initDoneB), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("noinit_done", 32'(initDoneB), 32'd1);
      checkOutput("noinit_cs",   32'(sramCsB),   32'd0);

      // Sweep: a write is requested partway through and must wait it out.
      for (int i = 0; i < 16; i++) begin
         checkOutput("sweep_cs",    32'(sramCs),   32'd1);
         checkOutput("sweep_wren",  32'(sramWren), 32'd1);
         checkOutput("sweep_mask",  32'(sramMask), 32'hF);
         checkOutput("sweep_data",  sramData,      32'd0);
         checkOutput("sweep_addr",  32'(sramAddr), 32'(i));
         checkOutput("sweep_done",  32'(initDone), 32'd0);
         checkOutput("sweep_ready", 32'(memReady), 32'd0);
         if (i < 2) checkOutput("noinit_quiet", 32'(sramCsB), 32'd0);
         if (i == 2) applyStimulus(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
         @(negedge clk);
         #1;
      end

      checkOutput("post_sweep_done",  32'(initDone), 32'd1);
      checkOutput("stalled_cs",       32'(sramCs),   32'd1);
      checkOutput("stalled_wren",     32'(sramWren), 32'd1);
      checkOutput("stalled_addr",     32'(sramAddr), 32'd2);
      checkOutput("stalled_mask",     32'(sramMask), 32'hF);
      checkOutput("stalled_data",     sramData,      32'hDEAD_BEEF);
      checkOutput("stalled_ready",    32'(memReady), 32'd0);
      @(negedge clk);
      checkOutput("stalled_ack",      32'(memReady), 32'd1);
      checkOutput("stalled_ack_cs",   32'(sramCs),   32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      #1;
      checkOutput("idle_ready", 32'(memReady), 32'd0);
      checkOutput("idle_cs",    32'(sramCs),   32'd0);
      for (int i = 0; i < 16; i++) begin
         checkOutput("array_after_sweep", sramArray[i], (i == 2) ? 32'hDEAD_BEEF : 32'd0);
      end

      doAccess(32'h4, 32'h1122_3344, 4'b0101, 32'd0);
      doAccess(32'h4, 32'd0, 4'd0, 32'h0022_0044);
      doAccess(32'h0, 32'hCAFE_F00D, 4'hF, 32'd0);
      doAccess(32'h0, 32'd0, 4'd0, 32'hCAFE_F00D);
      doAccess(32'h40, 32'd0, 4'd0, 32'hCAFE_F00D);
      doAccess(32'h0000_0F4B, 32'd0, 4'd0, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);

      // Reset lands on the cycle a read is being issued.
      applyStimulus(1'b1, 32'h4, 32'd0, 4'd0);
      #1;
      checkOutput("pre_rst_cs", 32'(sramCs), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_cs",    32'(sramCs),   32'd0);
      checkOutput("midrst_addr",  32'(sramAddr), 32'd0);
      checkOutput("midrst_ready", 32'(memReady), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      checkOutput("midrst_hold_ready", 32'(memReady), 32'd0);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         checkOutput("restart_cs",    32'(sramCs),   32'd1);
         checkOutput("restart_addr",  32'(sramAddr), 32'(i));
         checkOutput("restart_ready", 32'(memReady), 32'd0);
         @(negedge clk);
         #1;
      end
      checkOutput("restart_done",  32'(initDone), 32'd1);
      checkOutput("restart_ready", 32'(memReady), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
Initiator-side controller that turns the core's native valid/ready memory bus into the single-port synchronous SRAM macro interface (cs/addr/data/mask/wren, one-cycle registered read data). It sits between the bus interconnect and the SRAM macro wrapper. After reset it can optionally sweep-clear the whole array. It decodes byte strobes into SRAM write masks and returns read data with a fixed handshake latency.

Parameters:
ADDR_WIDTH, 10, SRAM word-address width; depth = 2**ADDR_WIDTH words of 32 bits.
INIT_EN, 1, 1 = zero-fill the entire SRAM after every reset; 0 = no sweep.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset, asynchronous, active-high.
mem_valid_i  input  1  bus request valid; held high until mem_ready_o is seen.
mem_ready_o  output  1  one-cycle completion pulse.
mem_addr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] are used.
mem_wdata_i  input  32  write data.
mem_wstrb_i  input  4  byte strobes; 0 = read, non-zero = write.
mem_rdata_o  output  32  read data; valid while mem_ready_o=1 for a read.
init_done_o  output  1  high once the controller accepts bus traffic.
sram_cs_o  output  1  SRAM chip select.
sram_addr_o  output  ADDR_WIDTH  SRAM word address.
sram_data_o  output  32  SRAM write data.
sram_mask_o  output  4  SRAM byte-write mask; bit n enables byte n.
sram_wren_o  output  1  1 = write, 0 = read.
sram_data_i  input  32  SRAM read data, valid the cycle after a read cs.

Behaviour:
- States: INIT, IDLE, WR_ACK, RD_ACK.
- Reset (asynchronous): state = INIT if INIT_EN=1, else IDLE. Init counter = 0.
- Reset values of all outputs: 0, including mem_ready_o, mem_rdata_o, init_done_o, and every sram_* output.
- Reset asserted mid-operation: all sram_* outputs drop to 0 immediately (combinationally). Any in-flight access is abandoned and never acknowledged.
- INIT:
  - Each cycle: cs=1, wren=1, mask=4'hF, data=0, addr=counter; counter increments.
  - On the cycle addr = 2**ADDR_WIDTH-1, go to IDLE. The sweep takes exactly 2**ADDR_WIDTH cycles.
  - mem_ready_o=0 throughout; bus requests stall and are not lost.
- init_done_o = 1 in every state except INIT (registered by state).
- IDLE, mem_valid_i=0: all sram_* outputs are 0.
- IDLE, mem_valid_i=1: SRAM is driven combinationally in the same cycle:
  - cs=1, addr=mem_addr_i[ADDR_WIDTH+1:2].
  - If wstrb≠0: wren=1, mask=wstrb, data=wdata; next state WR_ACK.
  - If wstrb=0: wren=0, mask=0, data=0; next state RD_ACK.
- WR_ACK: mem_ready_o=1, cs=0; next state IDLE.
- RD_ACK: mem_ready_o=1, mem_rdata_o=sram_data_i, cs=0; next state IDLE.
- mem_rdata_o is 0 in every state other than RD_ACK.
- Latency: ready is asserted exactly 1 cycle after the cycle in which valid is accepted, for both reads and writes. Throughput is one access per 2 cycles.
- The ACK states never issue a new access, even if mem_valid_i is still high. The request is re-evaluated in IDLE on the following cycle.
- Address handling: mem_addr_i[1:0] and bits above ADDR_WIDTH+1 are ignored; addresses alias modulo depth.
- Bus inputs are not registered. The master must hold addr, wdata and wstrb stable while valid is high.

Test Plan:
- Reset release with INIT_EN=1, ADDR_WIDTH=4 -> 16 consecutive cycles with cs=1, wren=1, mask=F, data=0, addr 0..15; init_done_o rises the cycle after addr=15; SRAM model reads all zeros.
- Bus write during INIT (addr 0x8, wdata 0xDEADBEEF, wstrb F) -> mem_ready_o held 0 until the sweep ends; then the write issues in IDLE and ready pulses 1 cycle later.
- Write addr 0x4, wdata 0x11223344, wstrb 4'b0101, then read addr 0x4 -> SRAM mask=0101; read returns 0x00220044 with ready exactly 1 cycle after valid.
- Back-to-back reads to addresses 0x0 and 0x40 (ADDR_WIDTH=4) with valid held continuously -> the second access aliases to word 0; each ready is a single-cycle pulse; cs is low in each ACK cycle.
- Reset asserted in the cycle a read is issued -> cs drops immediately; no ready pulse occurs; the INIT sweep restarts from addr 0.
- INIT_EN=0 -> init_done_o=1 on the first cycle after reset deasserts; no SRAM activity until mem_valid_i is asserted.
